// File: rtl/apb_mem_pkg.sv
// Shared types and address helpers for the APB memory slave.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int byte_lsb(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  // Out of range word index or a byte address not aligned to a full word.
  function automatic logic addr_err(input logic [63:0] addr, input int depth, input int data_w);
    logic [63:0] idx;
    logic [63:0] mask;
    int          lsb;
    lsb  = byte_lsb(data_w);
    idx  = addr >> lsb;
    mask = (64'd1 << lsb) - 64'd1;
    return (idx >= 64'(depth)) || ((addr & mask) != 64'd0);
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W storage: async clear, byte-enabled write, combinational read.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  we,
  input  logic [IDX_W-1:0]      widx,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [IDX_W-1:0]      ridx,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_r [DEPTH];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem_r[widx][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[ridx];

endmodule

// File: rtl/apb_mem_slave_p.sv
// APB3/APB4 word-addressed RAM completer with wait states and PSLVERR.
// Optional byte strobes: define APB_MEM_PSTRB_EN to add the PSTRB port.
module apb_mem_slave_p
  import apb_mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NB    = DATA_W / 8;
  localparam int LSB   = byte_lsb(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_C = 4'(WAIT_CYCLES);

  state_e              state_r, state_s;
  logic [3:0]          cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                wr_r, wr_s;
  logic [DATA_W-1:0]   wdata_r, wdata_s;
  logic [NB-1:0]       strb_r, strb_s;
  logic                err_r, err_s;
  logic                pready_r, pready_s;
  logic                pslverr_r, pslverr_s;
  logic [DATA_W-1:0]   prdata_r, prdata_s;

  logic [NB-1:0]       strb_in_s;
  logic                err_in_s;
  logic [IDX_W-1:0]    ridx_s;
  logic [DATA_W-1:0]   rdata_s;
  logic                mem_we_s;

`ifdef APB_MEM_PSTRB_EN
  assign strb_in_s = PSTRB;
`else
  assign strb_in_s = {NB{1'b1}};
`endif

  assign err_in_s = addr_err(64'(PADDR), DEPTH, DATA_W);
  // With zero wait states the read completes on the setup edge, before the address is latched.
  assign ridx_s   = (state_r == IDLE) ? IDX_W'(PADDR >> LSB) : IDX_W'(addr_r >> LSB);
  assign mem_we_s = (state_r == DONE) && wr_r && !err_r;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .we      (mem_we_s),
    .widx    (IDX_W'(addr_r >> LSB)),
    .wdata   (wdata_r),
    .wbe     (strb_r),
    .ridx    (ridx_s),
    .rdata   (rdata_s)
  );

  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    addr_s    = addr_r;
    wr_s      = wr_r;
    wdata_s   = wdata_r;
    strb_s    = strb_r;
    err_s     = err_r;
    pready_s  = pready_r;
    pslverr_s = pslverr_r;
    prdata_s  = prdata_r;
    case (state_r)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          addr_s  = PADDR;
          wr_s    = PWRITE;
          wdata_s = PWDATA;
          strb_s  = strb_in_s;
          err_s   = err_in_s;
          cnt_s   = 4'd0;
          if (WAIT_CYCLES == 0) begin
            pready_s  = 1'b1;
            pslverr_s = err_in_s;
            prdata_s  = (!PWRITE && !err_in_s) ? rdata_s : '0;
            state_s   = DONE;
          end else begin
            state_s = ACCESS;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          state_s = IDLE;
        end else if ((cnt_r + 4'd1) == WAIT_C) begin
          cnt_s     = cnt_r + 4'd1;
          pready_s  = 1'b1;
          pslverr_s = err_r;
          prdata_s  = (!wr_r && !err_r) ? rdata_s : '0;
          state_s   = DONE;
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      DONE: begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        state_s   = IDLE;
      end
      default: begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        state_s   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      addr_r    <= '0;
      wr_r      <= 1'b0;
      wdata_r   <= '0;
      strb_r    <= '0;
      err_r     <= 1'b0;
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= '0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      addr_r    <= addr_s;
      wr_r      <= wr_s;
      wdata_r   <= wdata_s;
      strb_r    <= strb_s;
      err_r     <= err_s;
      pready_r  <= pready_s;
      pslverr_r <= pslverr_s;
      prdata_r  <= prdata_s;
    end
  end

  assign PRDATA  = prdata_r;
  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;

endmodule

// File: tb/tb_apb_mem_slave_p.sv
// Scoreboard bench: dut_a uses 2 wait states, dut_b zero wait states.
module tb_apb_mem_slave_p;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        preset_n = 1'b0;
  logic        psel_a = 1'b0, psel_b = 1'b0;
  logic        penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = 12'h000;
  logic [31:0] pwdata = 32'h0;
  logic [3:0]  pstrb = 4'hF;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int   checks = 0;
  int   failures = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  always #5 clk = ~clk;

  apb_mem_slave_p #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .PCLK(clk), .PRESETn(preset_n), .PSEL(psel_a), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_mem_slave_p #(.DATA_W(32), .ADDR_W(12), .DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .PCLK(clk), .PRESETn(preset_n), .PSEL(psel_b), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata),
`ifdef APB_MEM_PSTRB_EN
    .PSTRB(pstrb),
`endif
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_sel(input int d, input logic v);
    if (d == 0) psel_a = v;
    else psel_b = v;
  endtask

  // Monitor: every completion on dut_a must match the oldest queued expectation.
  always @(negedge clk) begin
    if (preset_n && pready_a) begin
      if (q_a.size() == 0) begin
        check("unexpected_pready_a", 32'd1, 32'd0);
      end else begin
        e_a = q_a.pop_front();
        check("prdata_a", prdata_a, e_a.rdata);
        check("pslverr_a", {31'd0, pslverr_a}, {31'd0, e_a.err});
      end
    end
  end

  always @(negedge clk) begin
    if (preset_n && pready_b) begin
      if (q_b.size() == 0) begin
        check("unexpected_pready_b", 32'd1, 32'd0);
      end else begin
        e_b = q_b.pop_front();
        check("prdata_b", prdata_b, e_b.rdata);
        check("pslverr_b", {31'd0, pslverr_b}, {31'd0, e_b.err});
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after completion.
  task automatic xfer(input int d, input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [31:0] exp_rd, input logic exp_err,
                      input int exp_lat);
    exp_t e;
    int   lat;
    logic rdy;
    e.rdata = exp_rd;
    e.err   = exp_err;
    if (d == 0) q_a.push_back(e);
    else q_b.push_back(e);
    set_sel(d, 1'b1);
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    paddr  = addr ^ 12'h0F0;
    pwdata = ~wd;
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      rdy = (d == 0) ? pready_a : pready_b;
      if (rdy) break;
      @(posedge clk); #1;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    @(posedge clk); #1;
    set_sel(d, 1'b0);
    penable = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_pready", {31'd0, pready_a}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr_a}, 32'd0);
    check("rst_prdata", prdata_a, 32'd0);
    @(negedge clk) preset_n = 1'b1;
    @(posedge clk); #1;

    xfer(0, 1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1'b0, 3);

    // Reset while the write to 0x030 shows PREADY: outputs clear at once, write lost.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h030; pwdata = 32'hAAAA5555;
    @(posedge clk); #1; penable = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("pready_before_reset", {31'd0, pready_a}, 32'd1);
    preset_n = 1'b0;
    #1;
    check("reset_pready", {31'd0, pready_a}, 32'd0);
    check("reset_prdata", prdata_a, 32'd0);
    psel_a = 1'b0; penable = 1'b0;
    @(negedge clk) preset_n = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 12'h030, 32'h0, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF, 32'h0, 1'b0, 3);

    xfer(0, 1'b1, 12'h3FC, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h3FC, 32'h0, 4'hF, 32'h0BADF00D, 1'b0, 3);
    xfer(0, 1'b0, 12'h400, 32'h0, 4'hF, 32'h0, 1'b1, 3);
    xfer(0, 1'b1, 12'h002, 32'hCAFEF00D, 4'hF, 32'h0, 1'b1, 3);
    xfer(0, 1'b0, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0, 3);

    // Abort after one access cycle: no completion, memory untouched.
    psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020; pwdata = 32'h5555AAAA;
    @(posedge clk); #1; penable = 1'b1;
    @(posedge clk); #1; psel_a = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 32'h0, 1'b0, 3);

    // PENABLE high without a setup phase is ignored.
    psel_a = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 12'h040; pwdata = 32'h12345678;
    repeat (5) begin
      @(posedge clk); #1;
    end
    psel_a = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    xfer(0, 1'b0, 12'h040, 32'h0, 4'hF, 32'h0, 1'b0, 3);

    // Zero wait states, back-to-back.
    xfer(1, 1'b1, 12'h004, 32'h11223344, 4'hF, 32'h0, 1'b0, 1);
    xfer(1, 1'b0, 12'h004, 32'h0, 4'hF, 32'h11223344, 1'b0, 1);
    xfer(1, 1'b1, 12'h001, 32'h99999999, 4'hF, 32'h0, 1'b1, 1);
    xfer(1, 1'b0, 12'h000, 32'h0, 4'hF, 32'h0, 1'b0, 1);

`ifdef APB_MEM_PSTRB_EN
    xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 1'b1, 12'h008, 32'h00000000, 4'b0101, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'b0101, 32'hFF00FF00, 1'b0, 3);
    xfer(0, 1'b1, 12'h008, 32'h00000000, 4'b0000, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'h0, 32'hFF00FF00, 1'b0, 3);
`else
    xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b0, 3);
    xfer(0, 1'b1, 12'h008, 32'h00FF00FF, 4'b0101, 32'h0, 1'b0, 3);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF, 32'h00FF00FF, 1'b0, 3);
`endif

    repeat (3) @(posedge clk);
    check("queue_a_empty", 32'(q_a.size()), 32'd0);
    check("queue_b_empty", 32'(q_b.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
